// File: rtl/guess_evaluator.sv
// ============================================================================
// Module      : guess_evaluator
// Description : Scores a locked BCD guess against the secret, counts attempts
//               and latches the won/lost terminal state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module guess_evaluator #(
    parameter int MAX_ATTEMPTS = 7
) (
    input  logic       clk,
    input  logic       restart,
    input  logic [1:0] max_digits,
    input  logic       confirm,
    input  logic [3:0] compare_digit_1,
    input  logic [3:0] compare_digit_2,
    input  logic [3:0] compare_digit_3,
    input  logic [3:0] secret_digit_1,
    input  logic [3:0] secret_digit_2,
    input  logic [3:0] secret_digit_3,
    output logic [1:0] result,
    output logic       result_valid,
    output logic [1:0] digits_match,
    output logic [3:0] attempts_used,
    output logic [3:0] attempts_left,
    output logic       won,
    output logic       lost,
    output logic       busy
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_WAIT   = 3'd1;
    localparam logic [2:0] c_S_EVAL   = 3'd2;
    localparam logic [2:0] c_S_REPORT = 3'd3;
    localparam logic [2:0] c_S_WON    = 3'd4;
    localparam logic [2:0] c_S_LOST   = 3'd5;

    localparam logic [3:0] c_max_att  = 4'(MAX_ATTEMPTS);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_confirm_q;
    logic [11:0] r_guess;
    logic [11:0] r_secret;
    logic [1:0]  r_md;
    logic [1:0]  r_result;
    logic [1:0]  r_dm;
    logic [3:0]  r_used;
    logic        w_accept;
    logic [1:0]  w_cmp;
    logic [1:0]  w_match;
    logic [2:0]  w_pos_eq;

    assign w_accept = confirm & ~r_confirm_q & (r_state == c_S_IDLE) & (max_digits != 2'd0);

    // State register
    always_ff @(posedge clk) begin
        if (restart) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:   if (w_accept) w_next_state = c_S_WAIT;
            c_S_WAIT:   w_next_state = c_S_EVAL;
            c_S_EVAL:   w_next_state = c_S_REPORT;
            c_S_REPORT: begin
                if (r_result == 2'b11) begin
                    w_next_state = c_S_WON;
                end else if (r_used == c_max_att) begin
                    w_next_state = c_S_LOST;
                end else begin
                    w_next_state = c_S_IDLE;
                end
            end
            c_S_WON:    w_next_state = c_S_WON;
            c_S_LOST:   w_next_state = c_S_LOST;
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        result_valid = (r_state == c_S_REPORT);
        won          = (r_state == c_S_WON);
        lost         = (r_state == c_S_LOST);
        busy         = (r_state == c_S_WAIT) || (r_state == c_S_EVAL) || (r_state == c_S_REPORT);
    end

    // Positions beyond the latched digit count were zeroed in WAIT, so they
    // compare equal; the index test keeps them out of the match count.
    always_comb begin
        w_pos_eq[0] = (r_guess[3:0]  == r_secret[3:0])  && (r_md >= 2'd1);
        w_pos_eq[1] = (r_guess[7:4]  == r_secret[7:4])  && (r_md >= 2'd2);
        w_pos_eq[2] = (r_guess[11:8] == r_secret[11:8]) && (r_md == 2'd3);
        w_match     = {1'b0, w_pos_eq[0]} + {1'b0, w_pos_eq[1]} + {1'b0, w_pos_eq[2]};
        if (r_guess == r_secret) begin
            w_cmp = 2'b11;
        end else if (r_guess < r_secret) begin
            w_cmp = 2'b01;
        end else begin
            w_cmp = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            r_confirm_q <= 1'b0;
            r_guess     <= 12'd0;
            r_secret    <= 12'd0;
            r_md        <= 2'd0;
            r_result    <= 2'b00;
            r_dm        <= 2'd0;
            r_used      <= 4'd0;
        end else begin
            r_confirm_q <= confirm;
            if (r_state == c_S_WAIT) begin
                r_md     <= max_digits;
                r_guess  <= {(max_digits == 2'd3) ? compare_digit_3 : 4'd0,
                             (max_digits >= 2'd2) ? compare_digit_2 : 4'd0,
                             (max_digits >= 2'd1) ? compare_digit_1 : 4'd0};
                r_secret <= {(max_digits == 2'd3) ? secret_digit_3 : 4'd0,
                             (max_digits >= 2'd2) ? secret_digit_2 : 4'd0,
                             (max_digits >= 2'd1) ? secret_digit_1 : 4'd0};
            end
            if (r_state == c_S_EVAL) begin
                r_result <= w_cmp;
                r_dm     <= w_match;
                if (r_used != c_max_att) begin
                    r_used <= r_used + 4'd1;
                end
            end
        end
    end

    assign result        = r_result;
    assign digits_match  = r_dm;
    assign attempts_used = r_used;
    assign attempts_left = c_max_att - r_used;

endmodule

`default_nettype wire

// File: tb/tb_guess_evaluator.sv
// ============================================================================
// Module      : tb_guess_evaluator
// Description : Scoreboard bench for guess_evaluator (default and 3-attempt builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_guess_evaluator;

    logic       clk = 1'b0;
    logic       restart = 1'b1;
    logic       confirm = 1'b0;
    logic       confirm3 = 1'b0;
    logic [1:0] md = 2'd0;
    logic [3:0] g1 = 4'd0, g2 = 4'd0, g3 = 4'd0;
    logic [3:0] s1 = 4'd0, s2 = 4'd0, s3 = 4'd0;

    logic [1:0] res7, dm7, res3, dm3;
    logic       rv7, won7, lost7, busy7, rv3, won3, lost3, busy3;
    logic [3:0] used7, left7, used3, left3;

    int vectors = 0;
    int errors  = 0;
    int rv7_cnt = 0;
    int rv3_cnt = 0;
    int base;
    logic [7:0] q7[$];
    logic [7:0] q3[$];
    logic [7:0] e7, e3;

    guess_evaluator dut7 (
        .clk(clk), .restart(restart), .max_digits(md), .confirm(confirm),
        .compare_digit_1(g1), .compare_digit_2(g2), .compare_digit_3(g3),
        .secret_digit_1(s1), .secret_digit_2(s2), .secret_digit_3(s3),
        .result(res7), .result_valid(rv7), .digits_match(dm7),
        .attempts_used(used7), .attempts_left(left7),
        .won(won7), .lost(lost7), .busy(busy7)
    );

    guess_evaluator #(.MAX_ATTEMPTS(3)) dut3 (
        .clk(clk), .restart(restart), .max_digits(md), .confirm(confirm3),
        .compare_digit_1(g1), .compare_digit_2(g2), .compare_digit_3(g3),
        .secret_digit_1(s1), .secret_digit_2(s2), .secret_digit_3(s3),
        .result(res3), .result_valid(rv3), .digits_match(dm3),
        .attempts_used(used3), .attempts_left(left3),
        .won(won3), .lost(lost3), .busy(busy3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rv7) begin
            rv7_cnt++;
            if (q7.size() == 0) begin
                check("unexpected_valid7", 1, 0);
            end else begin
                e7 = q7.pop_front();
                check("score7", int'({res7, dm7, used7}), int'(e7));
            end
        end
        if (rv3) begin
            rv3_cnt++;
            if (q3.size() == 0) begin
                check("unexpected_valid3", 1, 0);
            end else begin
                e3 = q3.pop_front();
                check("score3", int'({res3, dm3, used3}), int'(e3));
            end
        end
    end

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
    endtask

    // One confirm pulse; checks the 2-cycle latency, returns at E3+1
    task automatic guess(input bit sel, input logic [3:0] a3, input logic [3:0] a2,
                         input logic [3:0] a1, input logic [1:0] er,
                         input logic [1:0] edm, input logic [3:0] eu);
        g3 = a3; g2 = a2; g1 = a1;
        if (sel) q3.push_back({er, edm, eu}); else q7.push_back({er, edm, eu});
        if (sel) confirm3 = 1'b1; else confirm = 1'b1;
        @(posedge clk);
        #1 confirm = 1'b0; confirm3 = 1'b0;
        check("lat_E0", int'(sel ? rv3 : rv7), 0);
        @(posedge clk);
        #1 check("lat_E1", int'(sel ? rv3 : rv7), 0);
        @(posedge clk);
        #1 check("lat_E2", int'(sel ? rv3 : rv7), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 restart = 1'b0;
        check("rst_result", int'(res7), 0);
        check("rst_valid", int'(rv7), 0);
        check("rst_dm", int'(dm7), 0);
        check("rst_used", int'(used7), 0);
        check("rst_left7", int'(left7), 7);
        check("rst_left3", int'(left3), 3);
        check("rst_won_lost_busy", int'({won7, lost7, busy7}), 0);

        // Basic score: 0x039 < 0x042
        md = 2'd2; s3 = 4'd0; s2 = 4'd4; s1 = 4'd2;
        guess(1'b0, 4'd0, 4'd3, 4'd9, 2'b01, 2'd0, 4'd1);
        check("basic_left", int'(left7), 6);
        check("basic_idle", int'({won7, lost7, busy7}), 0);

        // Win with masking: d2 garbage must be ignored
        do_restart();
        md = 2'd1; s3 = 4'd0; s2 = 4'd4; s1 = 4'd7;
        guess(1'b0, 4'd0, 4'd5, 4'd7, 2'b11, 2'd1, 4'd1);
        check("win_won", int'(won7), 1);
        base = rv7_cnt;
        confirm = 1'b1;
        repeat (2) @(posedge clk);
        #1 confirm = 1'b0;
        repeat (2) @(posedge clk);
        confirm = 1'b1;
        repeat (4) @(posedge clk);
        #1 confirm = 1'b0;
        check("won_no_valid", rv7_cnt - base, 0);
        check("won_used", int'(used7), 1);
        check("won_held", int'({won7, busy7}), 2);

        // Loss at limit (MAX_ATTEMPTS=3)
        do_restart();
        md = 2'd1; s3 = 4'd0; s2 = 4'd0; s1 = 4'd1;
        guess(1'b1, 4'd0, 4'd0, 4'd9, 2'b10, 2'd0, 4'd1);
        check("loss_left1", int'(left3), 2);
        check("loss_not_lost", int'(lost3), 0);
        guess(1'b1, 4'd0, 4'd0, 4'd9, 2'b10, 2'd0, 4'd2);
        guess(1'b1, 4'd0, 4'd0, 4'd9, 2'b10, 2'd0, 4'd3);
        check("loss_lost", int'({won3, lost3}), 1);
        check("loss_left0", int'(left3), 0);

        // Third guess correct wins over the attempt limit
        do_restart();
        guess(1'b1, 4'd0, 4'd0, 4'd9, 2'b10, 2'd0, 4'd1);
        guess(1'b1, 4'd0, 4'd0, 4'd9, 2'b10, 2'd0, 4'd2);
        guess(1'b1, 4'd0, 4'd0, 4'd1, 2'b11, 2'd1, 4'd3);
        check("last_win", int'({won3, lost3}), 2);

        // Held confirm gives one evaluation; re-press during EVAL ignored
        do_restart();
        md = 2'd2; s3 = 4'd0; s2 = 4'd4; s1 = 4'd2;
        g3 = 4'd0; g2 = 4'd5; g1 = 4'd0;
        q7.push_back({2'b10, 2'd0, 4'd1});
        q7.push_back({2'b10, 2'd0, 4'd2});
        base = rv7_cnt;
        confirm = 1'b1;
        @(posedge clk);
        #1 check("held_busy", int'(busy7), 1);
        repeat (9) @(posedge clk);
        #1 confirm = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("held_one_valid", rv7_cnt - base, 1);
        check("held_used", int'(used7), 1);
        base = rv7_cnt;
        confirm = 1'b1;
        @(posedge clk);
        #1 confirm = 1'b0;
        @(posedge clk);
        #1 confirm = 1'b1;
        @(posedge clk);
        #1 confirm = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("reedge_one_valid", rv7_cnt - base, 1);
        check("reedge_used", int'(used7), 2);

        // Restart at E1 aborts the evaluation
        base = rv7_cnt;
        q7.push_back({2'b10, 2'd0, 4'd3});
        confirm = 1'b1;
        @(posedge clk);
        #1 confirm = 1'b0; restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        void'(q7.pop_back());
        check("abort_outputs", int'({res7, rv7, dm7, used7, won7, lost7, busy7}), 0);
        check("abort_left", int'(left7), 7);
        repeat (4) @(posedge clk);
        #1 check("abort_no_valid", rv7_cnt - base, 0);
        check("abort_used", int'(used7), 0);

        // max_digits = 0 ignores confirm
        md = 2'd0;
        base = rv7_cnt;
        for (int i = 0; i < 3; i++) begin
            confirm = 1'b1;
            @(posedge clk);
            #1 confirm = 1'b0;
            check("md0_busy", int'(busy7), 0);
            @(posedge clk);
            #1 check("md0_busy", int'(busy7), 0);
        end
        repeat (3) @(posedge clk);
        #1 check("md0_no_valid", rv7_cnt - base, 0);
        check("md0_used", int'(used7), 0);

        check("q7_drained", q7.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
